// File: rtl/ieeedrv_sdarb_pkg.sv
// ieeedrv_sdarb_pkg
//  Shared types and helpers for the multi-drive SD-block arbiter.
//  Contents:
//   sdarb_state_t     arbiter FSM states
//   SDARB_MAX_SUBDRV  largest supported number of requesting subdrives
//   idx_w()           index width for n requesters (never below 1 bit)
//   wrap_idx()        (base + off) folded back into 0..n-1, for base,off < n
package ieeedrv_sdarb_pkg;

    localparam int SDARB_MAX_SUBDRV = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE,
        ABORT
    } sdarb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/ieeedrv_sdarb_if.sv
// ieeedrv_sdarb_if
//  Host-side virtual-disk channel shared by all subdrives.
//  Signals:
//   host_lba       block address of the granted request
//   host_blk_cnt   block count (blocks-1) of the granted request
//   host_rd        read request toward the host
//   host_wr        write request toward the host
//   host_ack       host acknowledge, high during the buffer transfer
//   host_buff_din  write data of the current owner
//  Modports:
//   master  the arbiter (drives the request side)
//   slave   the host (drives host_ack)
interface ieeedrv_sdarb_if #(
    parameter int LBA_W = 32,
    parameter int BLK_W = 6
) ();
    logic [LBA_W-1:0] host_lba;
    logic [BLK_W-1:0] host_blk_cnt;
    logic             host_rd;
    logic             host_wr;
    logic             host_ack;
    logic [7:0]       host_buff_din;

    modport master (
        output host_lba, host_blk_cnt, host_rd, host_wr, host_buff_din,
        input  host_ack
    );

    modport slave (
        input  host_lba, host_blk_cnt, host_rd, host_wr, host_buff_din,
        output host_ack
    );
endinterface

// File: rtl/ieeedrv_sdarb_rr_pick.sv
// ieeedrv_sdarb_rr_pick
//  Combinational round-robin picker: first set bit of 'pending' found by
//  scanning upward from 'ptr' and wrapping past N-1 to 0.
//  Ports:
//   pending  in   N      per-requester pending flags
//   ptr      in   IDX_W  highest-priority requester this round
//   idx      out  IDX_W  chosen requester (0 when none)
//   valid    out  1      some requester is pending
module ieeedrv_sdarb_rr_pick
    import ieeedrv_sdarb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down to ptr itself so the closest
    // pending requester is the last one written and therefore wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'(wrap_idx(int'(ptr), k, N));
            if (pending[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ieeedrv_sdarb.sv
// ieeedrv_sdarb
//  Multi-drive SD-block arbiter: serialises block read/write requests from
//  SUBDRV track engines onto one host virtual-disk channel and routes the
//  host acknowledge and buffer data to whichever drive owns the transfer.
//  Ports:
//   clk_sys      in   system clock
//   reset        in   synchronous active-high reset
//   req_rd       in   per-drive read request (level, held until own ack_o)
//   req_wr       in   per-drive write request (level, held until own ack_o)
//   req_lba      in   per-drive block address
//   req_blk_cnt  in   per-drive block count (blocks-1)
//   buff_din     in   per-drive write data
//   ack_o        out  host_ack routed to the owner only
//   busy         out  owner of the in-flight transfer
//   done         out  1-cycle pulse, transfer completed
//   err          out  1-cycle pulse, transfer aborted on ack timeout
//   host         ieeedrv_sdarb_if.master, host-side channel
//  Configuration:
//   IEEEDRV_SDARB_WRPRIO_EN  any pending write beats all reads (round-robin
//                            among writers); undefined: plain round-robin.
module ieeedrv_sdarb
    import ieeedrv_sdarb_pkg::*;
#(
    parameter int SUBDRV = 4,
    parameter int LBA_W  = 32,
    parameter int BLK_W  = 6,
    parameter int TMO_W  = 24
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic [SUBDRV-1:0]             req_rd,
    input  logic [SUBDRV-1:0]             req_wr,
    input  logic [SUBDRV-1:0][LBA_W-1:0]  req_lba,
    input  logic [SUBDRV-1:0][BLK_W-1:0]  req_blk_cnt,
    input  logic [SUBDRV-1:0][7:0]        buff_din,
    output logic [SUBDRV-1:0]             ack_o,
    output logic [SUBDRV-1:0]             busy,
    output logic [SUBDRV-1:0]             done,
    output logic [SUBDRV-1:0]             err,
    ieeedrv_sdarb_if.master               host
);

    localparam int IDX_W = idx_w(SUBDRV);

    sdarb_state_t     state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [TMO_W-1:0] tmo;
    logic [TMO_W-1:0] tmo_nxt;
    logic             ack_q;
    logic             ack_rise;
    logic [SUBDRV-1:0] pending;

    logic [LBA_W-1:0] lba_q;
    logic [BLK_W-1:0] blk_q;
    logic             rd_q;
    logic             wr_q;

`ifdef IEEEDRV_SDARB_WRPRIO_EN
    // Dirty tracks flush before any reload: reads only compete when no
    // drive has a write waiting.
    assign pending = (|req_wr) ? req_wr : req_rd;
`else
    assign pending = req_rd | req_wr;
`endif

    ieeedrv_sdarb_rr_pick #(
        .N     (SUBDRV),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .idx     (pick_idx),
        .valid   (pick_vld)
    );

    // Only a fresh ack edge starts a transfer; a level left high from an
    // earlier transfer must not complete a new one.
    assign ack_rise = host.host_ack & ~ack_q;
    assign tmo_nxt  = tmo + 1'b1;
    assign nxt_ptr  = (owner == IDX_W'(SUBDRV - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            tmo   <= '0;
            ack_q <= 1'b0;
            busy  <= '0;
            done  <= '0;
            err   <= '0;
            lba_q <= '0;
            blk_q <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
        end else begin
            ack_q <= host.host_ack;
            done  <= '0;
            err   <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner <= pick_idx;
                        lba_q <= req_lba[pick_idx];
                        blk_q <= req_blk_cnt[pick_idx];
                        // A drive asking for both gets its write first;
                        // its read stays pending for a later round.
                        wr_q  <= req_wr[pick_idx];
                        rd_q  <= ~req_wr[pick_idx];
                        busy  <= SUBDRV'(1) << pick_idx;
                        tmo   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack_rise) begin
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        state <= XFER;
                    end else begin
                        tmo <= tmo_nxt;
                        if (&tmo_nxt) begin
                            rd_q  <= 1'b0;
                            wr_q  <= 1'b0;
                            busy  <= '0;
                            err   <= SUBDRV'(1) << owner;
                            ptr   <= nxt_ptr;
                            state <= ABORT;
                        end
                    end
                end
                XFER: begin
                    if (!host.host_ack) begin
                        busy  <= '0;
                        done  <= SUBDRV'(1) << owner;
                        ptr   <= nxt_ptr;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The owner sees the ack from the very cycle it rises so it can drop
    // its request and catch the first buffer byte.
    always_comb begin
        ack_o = '0;
        if ((state == XFER) || ((state == ISSUE) && ack_rise))
            ack_o[owner] = host.host_ack;
    end

    assign host.host_lba      = lba_q;
    assign host.host_blk_cnt  = blk_q;
    assign host.host_rd       = rd_q;
    assign host.host_wr       = wr_q;
    assign host.host_buff_din = buff_din[owner];

endmodule
